// File: rtl/demux_4_stream.sv
// 1-to-4 valid/ready demultiplexer: each word goes to output a/b/c/d chosen by sel, one register stage per output.
// Latency: 1 cycle from accept to x_valid. Throughput is one word per cycle; a draining buffer refills on the same edge.
// Backpressure: in_ready reflects only the selected output's buffer, so a stalled consumer never blocks the others.
module demux_4_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] c_data,
    output logic             c_valid,
    input  logic             c_ready,
    output logic [WIDTH-1:0] d_data,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [CNT_W-1:0] count
);

    localparam int NOUT = 4;

    // Per-output buffer state, indexed 0=a .. 3=d
    logic [NOUT-1:0]  vld_q, vld_d;
    logic [WIDTH-1:0] dat_q [NOUT];
    logic [WIDTH-1:0] dat_d [NOUT];
    logic [CNT_W-1:0] count_q, count_d;

    logic [NOUT-1:0]  rdy_vec;
    logic [NOUT-1:0]  dlv;
    logic             sel_free;
    logic             acc;

    assign rdy_vec = {d_ready, c_ready, b_ready, a_ready};

    // A delivery happens wherever a buffer is occupied and its consumer takes it
    assign dlv = vld_q & rdy_vec;

    // The selected buffer can take a word if it is empty or is being emptied this cycle
    assign sel_free = ~vld_q[sel] | rdy_vec[sel];
    assign in_ready = ~rst & sel_free;
    assign acc      = in_valid & in_ready;

    // Next state of each output buffer: accept overrides drain so a same-cycle refill keeps valid high
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int i = 0; i < NOUT; i++) begin
            if (dlv[i]) begin
                vld_d[i] = 1'b0;
            end
            if (acc && (sel == 2'(i))) begin
                vld_d[i] = 1'b1;
                dat_d[i] = in_data;
            end
        end
    end

    // Delivered-word counter advances by the number of outputs handing off this cycle, wrapping silently
    always_comb begin
        count_d = count_q;
        for (int i = 0; i < NOUT; i++) begin
            count_d = count_d + CNT_W'(dlv[i]);
        end
    end

    // State registers; reset discards any buffered words
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < NOUT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
            for (int i = 0; i < NOUT; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign a_valid = vld_q[0];
    assign b_valid = vld_q[1];
    assign c_valid = vld_q[2];
    assign d_valid = vld_q[3];
    assign a_data  = dat_q[0];
    assign b_data  = dat_q[1];
    assign c_data  = dat_q[2];
    assign d_data  = dat_q[3];
    assign count   = count_q;

endmodule

// File: tb/tb_demux_4_stream.sv
// Directed bench for demux_4_stream: per-output expected-data queues filled on accept, drained by a monitor on delivery.
// Inputs change 1ns after the rising edge; everything is sampled on the falling edge.
module tb_demux_4_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sel;
    logic [3:0] rdy;
    logic [7:0] a_data, b_data, c_data, d_data;
    logic       a_valid, b_valid, c_valid, d_valid;
    logic [7:0] count;

    logic [3:0] vld_w;
    logic [7:0] dat_w [4];

    logic [7:0] expq [4][$];
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux_4_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .a_data(a_data), .a_valid(a_valid), .a_ready(rdy[0]),
        .b_data(b_data), .b_valid(b_valid), .b_ready(rdy[1]),
        .c_data(c_data), .c_valid(c_valid), .c_ready(rdy[2]),
        .d_data(d_data), .d_valid(d_valid), .d_ready(rdy[3]),
        .count(count)
    );

    assign vld_w    = {d_valid, c_valid, b_valid, a_valid};
    assign dat_w[0] = a_data;
    assign dat_w[1] = b_data;
    assign dat_w[2] = c_data;
    assign dat_w[3] = d_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake on an output must match the oldest word expected there
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (vld_w[k] && rdy[k]) begin
                    vectors++;
                    if (expq[k].size() == 0) begin
                        miscompares++;
                        $display("FAIL deliver_out%0d: got unexpected word %0h, expected none", k, dat_w[k]);
                    end else begin
                        logic [7:0] e;
                        e = expq[k].pop_front();
                        if (dat_w[k] !== e) begin
                            miscompares++;
                            $display("FAIL deliver_out%0d: got %0h, expected %0h", k, dat_w[k], e);
                        end
                    end
                end
            end
        end
    end

    // Present one word for one cycle, check in_ready against the hand-derived value, record it if taken
    task automatic offer(input logic [1:0] s, input logic [7:0] d, input logic exp_rdy);
        in_valid = 1'b1;
        sel      = s;
        in_data  = d;
        @(negedge clk);
        chk($sformatf("in_ready_sel%0d_%0h", s, d), 32'(in_ready), 32'(exp_rdy));
        if (in_ready) expq[s].push_back(d);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) expq[k].delete();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] t1 [4];
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        sel      = 2'd0;
        rdy      = 4'hF;

        // Reset state, with in_valid high to show in_ready is held low
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valids", 32'(vld_w), 32'd0);
        chk("rst_data", {a_data, b_data, c_data, d_data}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        do_reset();

        // 1: one word to each output back to back, each visible one cycle after accept
        t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            sel      = 2'(i);
            in_data  = t1[i];
            @(negedge clk);
            chk($sformatf("t1_in_ready_%0d", i), 32'(in_ready), 32'd1);
            if (i > 0) begin
                chk($sformatf("t1_valid_%0d", i - 1), 32'(vld_w[i-1]), 32'd1);
                chk($sformatf("t1_data_%0d", i - 1), 32'(dat_w[i-1]), 32'(t1[i-1]));
            end
            if (in_ready) expq[i].push_back(t1[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid_3", 32'(d_valid), 32'd1);
        chk("t1_data_3", 32'(d_data), 32'h44);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_count", 32'(count), 32'd4);
        @(posedge clk); #1;

        // 2: stalled output a, second word waits, then drain and refill on the same edge
        do_reset();
        rdy = 4'b1110;
        offer(2'd0, 8'hA0, 1'b1);
        in_valid = 1'b1; sel = 2'd0; in_data = 8'hA1;
        @(negedge clk);
        chk("t2_in_ready_blocked", 32'(in_ready), 32'd0);
        chk("t2_a_valid_held", 32'(a_valid), 32'd1);
        chk("t2_a_data_held", 32'(a_data), 32'hA0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_in_ready_still_blocked", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rdy = 4'hF;
        offer(2'd0, 8'hA1, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_a_valid_refill", 32'(a_valid), 32'd1);
        chk("t2_a_data_refill", 32'(a_data), 32'hA1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_count", 32'(count), 32'd2);
        @(posedge clk); #1;

        // 3: full stalled a does not block a word for b
        do_reset();
        rdy = 4'b1110;
        offer(2'd0, 8'hA7, 1'b1);
        offer(2'd1, 8'hB5, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_b_valid", 32'(b_valid), 32'd1);
        chk("t3_b_data", 32'(b_data), 32'hB5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_b_drained", 32'(b_valid), 32'd0);
        chk("t3_a_data_kept", 32'(a_data), 32'hA7);
        chk("t3_a_valid_kept", 32'(a_valid), 32'd1);
        chk("t3_count", 32'(count), 32'd1);
        @(posedge clk); #1;

        // 5: a and c full, one reset cycle discards everything
        rdy = 4'b1010;
        offer(2'd2, 8'hC3, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_pre_valids", 32'(vld_w), 32'b0101);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; sel = 2'd1; in_data = 8'h55;
        @(negedge clk);
        chk("t5_in_ready_in_rst", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 4; k++) expq[k].delete();
        rdy = 4'hF;
        @(negedge clk);
        chk("t5_valids", 32'(vld_w), 32'd0);
        chk("t5_data", {a_data, b_data, c_data, d_data}, 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        @(posedge clk); #1;

        // 4: 300 words round-robin with every consumer ready: no bubbles, count wraps to 44
        do_reset();
        for (int i = 0; i < 300; i++) begin
            offer(2'(i), 8'(i * 7 + 3), 1'b1);
        end
        idle(3);
        @(negedge clk);
        chk("t4_count", 32'(count), 32'd44);
        chk("t4_drained", 32'(expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()), 32'd0);
        @(posedge clk); #1;

        // 6: in_valid low with sel and data wandering: nothing is written, count holds
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sel     = 2'($urandom_range(0, 3));
            in_data = 8'($urandom);
            @(negedge clk);
            chk($sformatf("t6_valids_%0d", i), 32'(vld_w), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t6_count", 32'(count), 32'd44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net in case the sequence above ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000ns");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
